param_cacheline_adapter: RTL

//   Parametrised adapter between the last-level cache (one full line per request) and burst

---
 rtl/param_cacheline_adapter_pkg.sv | 32 +++
 rtl/param_cacheline_adapter_if.sv | 44 ++++
 rtl/param_cacheline_adapter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/param_cacheline_adapter_pkg.sv
// Shared types for the cache-line / burst-memory adapter.
//   state_t : controller state (IDLE, WRITE, READ, DONE)
//   op_t    : operation latched at request acceptance
//   op_decode() maps the read/write request pair onto an op_t.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        WB_RD = 2'd3
    } op_t;

    function automatic op_t op_decode(input logic rd, input logic wr);
        op_t op;
        case ({rd, wr})
            2'b01:   op = WR;
            2'b10:   op = RD;
            2'b11:   op = WB_RD;
            default: op = NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/param_cacheline_adapter_if.sv
// Bus bundle between the adapter, the last-level cache and burst memory.
//   Cache side : line_i, address_i, wb_address_i, read_i, write_i -> adapter
//                line_o, resp_o, busy_o                            <- adapter
//   Memory side: burst_i, resp_i                                   -> adapter
//                burst_o, address_o, read_o, write_o               <- adapter
//   slave  : the adapter's view
//   master : the environment's view (cache plus memory)
interface param_cacheline_adapter_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
);
    // cache side
    logic [LINE_WIDTH-1:0]  line_i;
    logic [ADDR_WIDTH-1:0]  address_i;
    logic [ADDR_WIDTH-1:0]  wb_address_i;
    logic                   read_i;
    logic                   write_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic                   resp_o;
    logic                   busy_o;
    // memory side
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [ADDR_WIDTH-1:0]  address_o;
    logic                   read_o;
    logic                   write_o;
    logic                   resp_i;

    modport slave (
        input  line_i, address_i, wb_address_i, read_i, write_i,
        output line_o, resp_o, busy_o,
        input  burst_i, resp_i,
        output burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, wb_address_i, read_i, write_i,
        input  line_o, resp_o, busy_o,
        output burst_i, resp_i,
        input  burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/param_cacheline_adapter.sv
// Adapter between the last-level cache (one whole line per request) and burst
// memory (BURST_WIDTH bits per beat). A line moves as BEATS beats, least
// significant beat first. read_i & write_i together performs a write-back of the
// latched line followed by a fill, answered by a single resp_o pulse.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : synchronous active-high reset
//   bus  : param_cacheline_adapter_if.slave (cache request/response + memory burst bus)
module param_cacheline_adapter
    import cla_pkg::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    param_cacheline_adapter_if.slave bus
);

    localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Parameter legality, checked at elaboration.
    if (LINE_WIDTH % BURST_WIDTH != 0) begin : g_chk_div
        $error("LINE_WIDTH must be a multiple of BURST_WIDTH");
    end
    if (BEATS < 2) begin : g_chk_beats
        $error("LINE_WIDTH/BURST_WIDTH must be at least 2");
    end
    if (LINE_WIDTH % 8 != 0) begin : g_chk_bytes
        $error("LINE_WIDTH must be a whole number of bytes");
    end
    if (OFFSET < 1 || OFFSET >= ADDR_WIDTH) begin : g_chk_offset
        $error("line offset must fit inside ADDR_WIDTH");
    end

    // Addresses are stored already line-aligned so the output mux needs no masking.
    function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
    endfunction

    state_t                            state_q, state_d;
    op_t                               op_q, op_d;
    logic [CNT_W-1:0]                  beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]             rd_addr_q, wb_addr_q;
    logic [BEATS-1:0][BURST_WIDTH-1:0] buf_q;
    logic                              accept;
    logic                              fill;
    logic                              last_beat;

    assign last_beat = (beat_q == LAST_BEAT);

    // Next state and all outputs. Outputs depend only on registered state, so
    // a stalled memory (resp_i low) sees them held unchanged.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        beat_d        = beat_q;
        accept        = 1'b0;
        fill          = 1'b0;
        bus.line_o    = '0;
        bus.resp_o    = 1'b0;
        bus.busy_o    = (state_q != IDLE);
        bus.burst_o   = '0;
        bus.address_o = '0;
        bus.read_o    = 1'b0;
        bus.write_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.read_i || bus.write_i) begin
                    accept  = 1'b1;
                    op_d    = op_decode(bus.read_i, bus.write_i);
                    beat_d  = '0;
                    // Any write (plain or write-back) starts with the WRITE phase.
                    state_d = bus.write_i ? WRITE : READ;
                end
            end

            WRITE: begin
                bus.write_o   = 1'b1;
                bus.address_o = wb_addr_q;
                bus.burst_o   = buf_q[beat_q];
                if (bus.resp_i) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        // Write-back flows straight into the fill, no idle cycle.
                        state_d = (op_q == WB_RD) ? READ : DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            READ: begin
                bus.read_o    = 1'b1;
                bus.address_o = rd_addr_q;
                if (bus.resp_i) begin
                    fill = 1'b1;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            DONE: begin
                // A plain write hands back the line it wrote.
                bus.resp_o = 1'b1;
                bus.line_o = buf_q;
                op_d       = NONE;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= NONE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            beat_q  <= beat_d;
        end
    end

    // Datapath needs no reset: contents are only observed after a fresh acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q     <= bus.line_i;
            rd_addr_q <= align(bus.address_i);
            wb_addr_q <= align((bus.read_i && bus.write_i) ? bus.wb_address_i : bus.address_i);
        end else if (fill) begin
            buf_q[beat_q] <= bus.burst_i;
        end
    end

endmodule
